sevenseg_frame_driver: RTL and testbench

- Downstream consumer of the 0-4 display-select counter in the slot-machine display path.
- Holds a double-buffered 5-digit hex frame from the MCU-side logic and decodes the selected digit to 7-segment patterns.
- Drives active-low segment and anode lines for 5 multiplexed common-anode displays.
- Inserts an anode-off blanking gap at every select change to prevent ghosting, and swaps frames only at refresh boundaries so a frame is never torn.

---
 rtl/sevenseg_frame_driver.sv | 167 ++++++++++++++++
 tb/tb_sevenseg_frame_driver.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_frame_driver.sv
// Purpose: double-buffered 5-digit hex frame -> multiplexed active-low 7-segment/anode drive.
// Latency: segments update 1 clk after a select change; the anode lights BLANK_CYCLES+1 clks after it.
// Backpressure: frame_ready drops once a frame is captured and recovers 1 clk after the refresh-wrap swap.
//
// Ports:
//   clk, reset_n       clock and asynchronous active-low reset
//   sel                display select from the refresh counter (0..NUM_DIGITS-1 valid)
//   frame_digits/dp    new frame (digit i at [4i+3:4i]) and decimal points, 1 = lit
//   frame_valid/ready  frame handshake; capture when both high
//   digit_en           live per-digit enable, 0 = anode kept off
//   blink_mask         per-digit blink select (only when DISP_BLINK_EN is defined)
//   seg_n, dp_n, an_n  registered active-low segment {g..a}, decimal point and anode lines
//
// Build option: define DISP_BLINK_EN to add blink_mask and the free-running blink timer.
module sevenseg_frame_driver #(
  parameter int NUM_DIGITS        = 5,
  parameter int BLANK_CYCLES      = 64,
  parameter int BLINK_HALF_CYCLES = 6375000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              sel,
  input  logic [4*NUM_DIGITS-1:0] frame_digits,
  input  logic [NUM_DIGITS-1:0]   frame_dp,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  input  logic [NUM_DIGITS-1:0]   digit_en,
`ifdef DISP_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n
);

  localparam int             BW         = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0]  BLANK_LOAD = BW'(BLANK_CYCLES - 1);
  localparam logic [2:0]     LAST_SEL   = 3'(NUM_DIGITS - 1);
  localparam logic [3:0]     NUM_SEL    = 4'(NUM_DIGITS);

  if (BLANK_CYCLES < 1 || BLINK_HALF_CYCLES < 1) begin : g_bad_params
    $error("sevenseg_frame_driver: BLANK_CYCLES and BLINK_HALF_CYCLES must be >= 1");
  end

  logic [4*NUM_DIGITS-1:0] act_digits, shd_digits, act_digits_nxt;
  logic [NUM_DIGITS-1:0]   act_dp, shd_dp, act_dp_nxt;
  logic                    pending;
  logic                    armed;
  logic [2:0]              sel_q;
  logic [BW-1:0]           blank_cnt;
  logic [NUM_DIGITS-1:0]   en_eff;
  logic                    sel_chg, sel_ok, swap, capture;
  logic [3:0]              dig_nxt;
  logic                    dp_bit_nxt;
  logic                    en_cur;
  logic [NUM_DIGITS-1:0]   an_lit;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign frame_ready = ~pending;

  always_comb begin
    sel_chg        = (sel != sel_q);
    sel_ok         = ({1'b0, sel} < NUM_SEL);
    // Swap only on the last->first wrap, so a refresh always shows one whole frame.
    swap           = pending && (sel_q == LAST_SEL) && (sel == 3'd0);
    capture        = frame_valid && !pending;
    act_digits_nxt = swap ? shd_digits : act_digits;
    act_dp_nxt     = swap ? shd_dp : act_dp;
    dig_nxt        = 4'h0;
    dp_bit_nxt     = 1'b0;
    en_cur         = 1'b0;
    an_lit         = '1;
    // Loop-based mux keeps out-of-range selects from indexing past the buffers.
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel == 3'(i)) begin
        dig_nxt    = act_digits_nxt[4*i +: 4];
        dp_bit_nxt = act_dp_nxt[i];
      end
      if (sel_q == 3'(i)) begin
        en_cur    = en_eff[i];
        an_lit[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_digits <= '0;
      act_dp     <= '0;
      shd_digits <= '0;
      shd_dp     <= '0;
      pending    <= 1'b0;
    end else begin
      act_digits <= act_digits_nxt;
      act_dp     <= act_dp_nxt;
      if (swap) begin
        pending <= 1'b0;
      end else if (capture) begin
        shd_digits <= frame_digits;
        shd_dp     <= frame_dp;
        pending    <= 1'b1;
      end
    end
  end

  // armed stays low until the first select change, so a counter that is
  // already zero out of reset does not light a digit without a blank gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q     <= 3'd0;
      armed     <= 1'b0;
      blank_cnt <= '0;
      seg_n     <= 7'h7F;
      dp_n      <= 1'b1;
      an_n      <= '1;
    end else if (sel_chg) begin
      sel_q     <= sel;
      armed     <= 1'b1;
      blank_cnt <= BLANK_LOAD;
      an_n      <= '1;
      seg_n     <= sel_ok ? hex_to_seg(dig_nxt) : 7'h7F;
      dp_n      <= sel_ok ? ~dp_bit_nxt : 1'b1;
    end else if (blank_cnt != '0) begin
      blank_cnt <= blank_cnt - BW'(1);
      an_n      <= '1;
    end else begin
      // Re-evaluated every cycle so digit_en (and blink) act on a lit anode at once.
      an_n <= (armed && en_cur) ? an_lit : '1;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int            KW        = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam logic [KW-1:0] BLINK_TOP = KW'(BLINK_HALF_CYCLES - 1);

  logic [KW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_TOP) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + KW'(1);
    end
  end

  // During the dark phase a blinking digit behaves exactly like a disabled one.
  assign en_eff = digit_en & ~(blink_mask & {NUM_DIGITS{blink_phase}});
`else
  assign en_eff = digit_en;
`endif

endmodule

// File: tb/tb_sevenseg_frame_driver.sv
module tb_sevenseg_frame_driver;
  localparam int BLANK = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic [19:0] frame_digits = '0;
  logic [4:0]  frame_dp = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [4:0]  digit_en = 5'h1F;
`ifdef DISP_BLINK_EN
  logic [4:0]  blink_mask = 5'h00;
`endif
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [4:0]  an_n;

  sevenseg_frame_driver #(
`ifdef DISP_BLINK_EN
    .BLINK_HALF_CYCLES(1000),
`endif
    .NUM_DIGITS(5),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sel(sel),
    .frame_digits(frame_digits), .frame_dp(frame_dp),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .digit_en(digit_en),
`ifdef DISP_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic [19:0] digits;
    logic [4:0]  dp;
    logic [2:0]  sel;
    logic [6:0]  exp_seg;
    logic        exp_dp_n;
    logic [4:0]  exp_an;
  } vec_t;
  vec_t vecs [16];

  // Reference model: frame buffers as digit arrays, blanking as cycles since the last select change.
  int         m_act_d [5];
  int         m_sh_d  [5];
  bit         m_act_p [5];
  bit         m_sh_p  [5];
  bit         m_pend, m_armed;
  int         m_selq, m_age;
  logic [6:0] m_seg;
  logic       m_dp_n;
  logic [4:0] m_an;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    sel = 3'd0;
    frame_valid = 1'b0;
    reset_n = 1'b0;
    ticks(2);
    reset_n = 1'b1;
    tick();
  endtask

  // Call right after moving sel: anodes dark for BLANK edges, lit on the next.
  task automatic expect_light(input string name, input logic [4:0] exp_an);
    bit ok = 1'b1;
    for (int k = 0; k < BLANK; k++) begin
      tick();
      if (an_n !== 5'h1F) ok = 1'b0;
    end
    check({name, "_gap"}, ok, 1);
    tick();
    check({name, "_an"}, an_n, exp_an);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_act_d[i] = 0; m_sh_d[i] = 0; m_act_p[i] = 0; m_sh_p[i] = 0;
    end
    m_pend = 0; m_armed = 0; m_selq = 0; m_age = 0;
    m_seg = 7'h7F; m_dp_n = 1'b1; m_an = 5'h1F;
  endtask

  task automatic model_step();
    int  s;
    bit  chg, swp, cap;
    s   = int'(sel);
    chg = (s != m_selq);
    swp = m_pend && (m_selq == 4) && (s == 0);
    cap = frame_valid && !m_pend;
    if (swp) begin
      m_act_d = m_sh_d;
      m_act_p = m_sh_p;
      m_pend  = 0;
    end else if (cap) begin
      for (int i = 0; i < 5; i++) begin
        m_sh_d[i] = int'(frame_digits[4*i +: 4]);
        m_sh_p[i] = frame_dp[i];
      end
      m_pend = 1;
    end
    if (chg) begin
      m_selq  = s;
      m_age   = 0;
      m_armed = 1;
      m_an    = 5'h1F;
      if (s < 5) begin
        m_seg  = HEX[m_act_d[s]];
        m_dp_n = !m_act_p[s];
      end else begin
        m_seg  = 7'h7F;
        m_dp_n = 1'b1;
      end
    end else begin
      if (m_age < BLANK) m_age++;
      if (m_armed && m_age >= BLANK && m_selq < 5 && digit_en[m_selq])
        m_an = ~(5'b00001 << m_selq);
      else
        m_an = 5'h1F;
    end
  endtask

  initial begin
    bit ok;
    int hold;
    int p;

    for (int v = 0; v < 16; v++) begin
      p = v % 5;
      vecs[v].digits   = 20'(v) << (4 * p);
      vecs[v].dp       = (v % 2 == 1) ? 5'(1 << p) : 5'h00;
      vecs[v].sel      = 3'(p);
      vecs[v].exp_seg  = HEX[v];
      vecs[v].exp_dp_n = (v % 2 == 1) ? 1'b0 : 1'b1;
      vecs[v].exp_an   = ~5'(1 << p);
    end

    // Reset mid-blank, with sel pulsing.
    ticks(3);
    reset_n = 1'b1;
    tick();
    sel = 3'd1; ticks(5);
    sel = 3'd3; ticks(2);
    #3 reset_n = 1'b0;
    #1;
    check("rst_seg", seg_n, 7'h7F);
    check("rst_dp", dp_n, 1'b1);
    check("rst_an", an_n, 5'h1F);
    check("rst_ready", frame_ready, 1'b1);
    @(posedge clk); #1;
    sel = 3'd2; tick();
    sel = 3'd0; ticks(2);
    reset_n = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (an_n !== 5'h1F || frame_ready !== 1'b1) ok = 1'b0;
    end
    check("rst_release_idle", ok, 1);

    // Frame load and swap at the wrap.
    frame_digits = 20'h43210; frame_dp = 5'b00100; frame_valid = 1'b1;
    check("t2_ready_before", frame_ready, 1'b1);
    tick();
    frame_valid = 1'b0;
    check("t2_ready_after_cap", frame_ready, 1'b0);
    for (int s = 1; s <= 4; s++) begin
      sel = 3'(s); ticks(200);
      if (s == 2) check("t2_old_frame_seg", seg_n, 7'h40);
    end
    check("t2_ready_pending", frame_ready, 1'b0);
    sel = 3'd0; tick();
    check("t2_ready_after_swap", frame_ready, 1'b1);
    ticks(199);
    sel = 3'd1; ticks(200);
    sel = 3'd2;
    expect_light("t2", 5'b11011);
    check("t2_seg", seg_n, 7'h24);
    check("t2_dp", dp_n, 1'b0);

    // Second frame offered while one is pending.
    sel = 3'd3; ticks(200);
    sel = 3'd4; ticks(200);
    sel = 3'd0; ticks(200);
    frame_digits = 20'h89ABC; frame_dp = 5'b10000; frame_valid = 1'b1;
    tick();
    frame_digits = 20'h55555; frame_dp = 5'b00000;
    check("t3_ready_cap", frame_ready, 1'b0);
    for (int s = 1; s <= 4; s++) begin
      sel = 3'(s); ticks(200);
      check("t3_ready_hold", frame_ready, 1'b0);
      if (s == 3) begin
        check("t3_old_seg", seg_n, 7'h30);
        check("t3_old_dp", dp_n, 1'b1);
      end
    end
    sel = 3'd0; tick();
    check("t3_ready_swap", frame_ready, 1'b1);
    tick();
    check("t3_second_accept", frame_ready, 1'b0);
    frame_valid = 1'b0;
    check("t3_new_seg0", seg_n, 7'h46);
    check("t3_new_dp0", dp_n, 1'b1);
    sel = 3'd4; ticks(70);
    check("t3_new_seg4", seg_n, 7'h00);
    check("t3_new_dp4", dp_n, 1'b0);
    check("t3_new_an4", an_n, 5'b01111);

    // Select change during blanking restarts the gap.
    sel = 3'd1;
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (an_n !== 5'h1F) ok = 1'b0;
    end
    check("t4_first_gap", ok, 1);
    sel = 3'd2;
    expect_light("t4", 5'b11011);
    check("t4_seg", seg_n, 7'h08);

    // Disabled digit and out-of-range select.
    digit_en = 5'b11101;
    sel = 3'd1;
    ok = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (an_n !== 5'h1F) ok = 1'b0;
    end
    check("t5_dark", ok, 1);
    check("t5_seg_decoded", seg_n, 7'h03);
    sel = 3'd6; ticks(100);
    check("t5_oor_seg", seg_n, 7'h7F);
    check("t5_oor_dp", dp_n, 1'b1);
    check("t5_oor_an", an_n, 5'h1F);
    digit_en = 5'h1F; ticks(70);
    check("t5_oor_an_en", an_n, 5'h1F);

    // Decode table through the full handshake/swap path.
    do_reset();
    for (int v = 0; v < 16; v++) begin
      check("tbl_ready", frame_ready, 1'b1);
      frame_digits = vecs[v].digits; frame_dp = vecs[v].dp; frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
      sel = 3'd4; ticks(3);
      sel = 3'd0; tick();
      sel = vecs[v].sel; ticks(70);
      check($sformatf("tbl_seg_%0d", v), seg_n, vecs[v].exp_seg);
      check($sformatf("tbl_dp_%0d", v), dp_n, vecs[v].exp_dp_n);
      check($sformatf("tbl_an_%0d", v), an_n, vecs[v].exp_an);
    end

`ifdef DISP_BLINK_EN
    begin
      int last, toggles;
      logic prev;
      do_reset();
      blink_mask = 5'b00001;
      sel = 3'd1; ticks(3);
      sel = 3'd0; ticks(70);
      ok = 1'b1; last = -1; toggles = 0; prev = an_n[0];
      for (int k = 0; k < 4500; k++) begin
        tick();
        if (an_n[4:1] !== 4'hF) ok = 1'b0;
        if (an_n[0] !== prev) begin
          if (last >= 0) check("blink_period", k - last, 1000);
          last = k;
          toggles++;
          prev = an_n[0];
        end
      end
      check("blink_others_dark", ok, 1);
      check("blink_toggles", toggles >= 3, 1);
      blink_mask = 5'h00;
    end
`endif

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 99) < 85) sel = (sel >= 3'd4) ? 3'd0 : sel + 3'd1;
        else                            sel = 3'($urandom_range(0, 7));
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20))
                                           : int'($urandom_range(60, 150));
      end else begin
        hold--;
      end
      frame_valid  = ($urandom_range(0, 2) == 0);
      frame_digits = 20'($urandom);
      frame_dp     = 5'($urandom);
      if ($urandom_range(0, 199) == 0) digit_en = 5'($urandom);
      tick();
      model_step();
      check("rand_seg_dp_an_ready", {seg_n, dp_n, an_n, frame_ready},
            {m_seg, m_dp_n, m_an, ~m_pend});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
